// File: rtl/inbuf_reader.sv
// Raster-scan frame-memory reader: issues one RAM read per pixel and streams pixels out
// with sof/eol/eof markers. Optional INBUF_RD_SWAP_RB_EN swaps the R and B bytes (BGR out).
module inbuf_reader #(
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned ADDR_W     = 17,
  parameter int unsigned H_RES      = 480,
  parameter int unsigned V_RES      = 272,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clka,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_ena,
  output logic              mem_wea,
  output logic [ADDR_W-1:0] mem_addra,
  input  logic [DATA_W-1:0] mem_douta,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_sof,
  output logic              m_eol,
  output logic              m_eof
);

  localparam int unsigned NPIX      = H_RES * V_RES;
  localparam int unsigned LAST_ADDR = NPIX - 1;
  localparam int unsigned PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned X_W       = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int unsigned Y_W       = (V_RES > 1) ? $clog2(V_RES) : 1;

  typedef struct packed {
    logic              sof;
    logic              eol;
    logic              eof;
    logic [DATA_W-1:0] data;
  } pix_t;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_mem_ena;
  logic              w_ena_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [RD_LAT-1:0] r_cap;
  logic [RD_LAT-1:0] w_cap_nxt;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_count_nxt;
  logic [CNT_W-1:0]  w_infl_nxt;
  logic [CNT_W:0]    w_credit_sum;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [X_W-1:0]    r_x;
  logic [Y_W-1:0]    r_y;
  logic              r_valid;
  logic              r_busy;
  logic              r_done;
  pix_t              r_fifo [FIFO_DEPTH];
  pix_t              w_head;
  pix_t              w_push_pix;
  logic              w_push;
  logic              w_pop;
  logic              w_last_issue;
  logic              w_start_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_push       = r_cap[RD_LAT-1];
  assign w_pop        = r_valid && m_ready;
  assign w_last_issue = r_mem_ena && (r_addr == ADDR_W'(LAST_ADDR));
  assign w_start_ok   = (r_state == S_IDLE) && start;
  assign w_head       = r_fifo[r_rd_ptr];

  assign w_push_pix.sof  = (r_x == '0) && (r_y == '0);
  assign w_push_pix.eol  = (r_x == X_W'(H_RES - 1));
  assign w_push_pix.eof  = (r_x == X_W'(H_RES - 1)) && (r_y == Y_W'(V_RES - 1));
  assign w_push_pix.data = mem_douta;

  // Next state plus a one-cycle look-ahead of the credit check so mem_ena is a flop
  always_comb begin
    w_state_nxt  = r_state;
    w_cap_nxt    = r_cap << 1;
    w_cap_nxt[0] = r_mem_ena;
    w_count_nxt  = r_count;
    w_infl_nxt   = '0;
    w_credit_sum = '0;
    w_ena_nxt    = 1'b0;

    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last_issue) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_pop && w_head.eof) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CNT_W'(1);
    end

    for (int i = 0; i < int'(RD_LAT); i++) begin
      w_infl_nxt = w_infl_nxt + CNT_W'(w_cap_nxt[i]);
    end

    w_credit_sum = {1'b0, w_count_nxt} + {1'b0, w_infl_nxt};
    w_ena_nxt    = (w_state_nxt == S_RUN) && (w_credit_sum < (CNT_W + 1)'(FIFO_DEPTH));
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_mem_ena <= 1'b0;
      r_addr    <= '0;
      r_cap     <= '0;
      r_count   <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_mem_ena <= w_ena_nxt;
      r_cap     <= w_cap_nxt;
      r_count   <= w_count_nxt;
      r_valid   <= (w_count_nxt != '0);
      r_busy    <= (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
      r_done    <= (w_state_nxt == S_DONE);

      // Address parks on the last pixel; a new frame restarts it from zero
      if (w_start_ok) begin
        r_addr <= '0;
      end else if (r_mem_ena && !w_last_issue) begin
        r_addr <= r_addr + ADDR_W'(1);
      end

      if (w_start_ok) begin
        r_x <= '0;
        r_y <= '0;
      end else if (w_push) begin
        if (w_push_pix.eol) begin
          r_x <= '0;
          r_y <= w_push_pix.eof ? '0 : r_y + Y_W'(1);
        end else begin
          r_x <= r_x + X_W'(1);
        end
      end

      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
    end
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) r_fifo[i] <= '0;
    end else if (w_push) begin
      r_fifo[r_wr_ptr] <= w_push_pix;
    end
  end

  a_no_overflow: assert property (@(posedge clka) disable iff (!rst_n)
    w_push |-> (r_count < CNT_W'(FIFO_DEPTH)));

  assign busy      = r_busy;
  assign done      = r_done;
  assign mem_ena   = r_mem_ena;
  assign mem_wea   = 1'b0;
  assign mem_addra = r_addr;
  assign m_valid   = r_valid;
  assign m_sof     = w_head.sof;
  assign m_eol     = w_head.eol;
  assign m_eof     = w_head.eof;
`ifdef INBUF_RD_SWAP_RB_EN
  assign m_data    = {w_head.data[7:0], w_head.data[15:8], w_head.data[23:16]};
`else
  assign m_data    = w_head.data;
`endif

endmodule

// File: tb/tb_inbuf_reader.sv
// Directed bench for inbuf_reader on a 4x3 frame; RAM model returns word = address.
module tb_inbuf_reader;
  localparam int unsigned DW = 24;
  localparam int unsigned AW = 17;

  logic          clka = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          m_ready = 1'b0;
  logic          busy, done, mem_ena, mem_wea, m_valid, m_sof, m_eol, m_eof;
  logic [AW-1:0] mem_addra;
  logic [DW-1:0] mem_douta = '0;
  logic [DW-1:0] m_data;

  logic          start2 = 1'b0;
  logic          m_ready2 = 1'b1;
  logic          busy2, done2, mem_ena2, mem_wea2, m_valid2, m_sof2, m_eol2, m_eof2;
  logic [AW-1:0] mem_addra2;
  logic [DW-1:0] mem_douta2, m_data2;
  logic [DW-1:0] q2a = '0;
  logic [DW-1:0] q2b = '0;

  int checks = 0;
  int errors = 0;

  always #5 clka = ~clka;

  always @(posedge clka) if (mem_ena) mem_douta <= DW'(mem_addra);

  // Two-stage RAM for the RD_LAT = 2 instance
  always @(posedge clka) begin
    if (mem_ena2) q2a <= 24'h112233 + DW'(mem_addra2);
    q2b <= q2a;
  end
  assign mem_douta2 = q2b;

  inbuf_reader #(.DATA_W(DW), .ADDR_W(AW), .H_RES(4), .V_RES(3), .RD_LAT(1), .FIFO_DEPTH(4)) u_dut (
    .clka(clka), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .mem_ena(mem_ena), .mem_wea(mem_wea), .mem_addra(mem_addra), .mem_douta(mem_douta),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof)
  );

  inbuf_reader #(.DATA_W(DW), .ADDR_W(AW), .H_RES(4), .V_RES(3), .RD_LAT(2), .FIFO_DEPTH(4)) u_dut2 (
    .clka(clka), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
    .mem_ena(mem_ena2), .mem_wea(mem_wea2), .mem_addra(mem_addra2), .mem_douta(mem_douta2),
    .m_valid(m_valid2), .m_ready(m_ready2), .m_data(m_data2),
    .m_sof(m_sof2), .m_eol(m_eol2), .m_eof(m_eof2)
  );

  function automatic logic [23:0] exp_px(input logic [23:0] w);
`ifdef INBUF_RD_SWAP_RB_EN
    return {w[7:0], w[15:8], w[23:16]};
`else
    return w;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_ena"}, 32'(mem_ena), 0);
    check({tag, "_wea"}, 32'(mem_wea), 0);
    check({tag, "_addr"}, 32'(mem_addra), 0);
    check({tag, "_valid"}, 32'(m_valid), 0);
    check({tag, "_data"}, 32'(m_data), 0);
    check({tag, "_marks"}, 32'({m_sof, m_eol, m_eof}), 0);
  endtask

  // Pixel consumed at stream index n must carry word n and its raster markers
  task automatic check_pix(input string tag, input int n);
    check({tag, "_data"}, 32'(m_data), 32'(exp_px(24'(n))));
    check({tag, "_sof"}, 32'(m_sof), 32'(n == 0));
    check({tag, "_eol"}, 32'(m_eol), 32'(n % 4 == 3));
    check({tag, "_eof"}, 32'(m_eof), 32'(n == 11));
  endtask

  initial begin
    int n, nd, issued, popped;
    bit hit, first;

    repeat (3) @(negedge clka);
    check_reset("rst");
    rst_n = 1'b1;

    // Continuous ready
    m_ready = 1'b1; n = 0; nd = 0;
    @(negedge clka); start = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clka); start = 1'b0;
      if (k == 1) begin
        check("a_busy1", 32'(busy), 1);
        check("a_ena1", 32'(mem_ena), 1);
        check("a_addr1", 32'(mem_addra), 0);
      end
      if (m_valid && m_ready) begin
        check("a_time", k, 3 + n);
        check_pix("a", n);
        n++;
      end
      if (done) begin
        check("a_done_t", k, 15);
        check("a_busy_at_done", 32'(busy), 0);
        nd++;
      end
    end
    check("a_npix", n, 12);
    check("a_ndone", nd, 1);

    // Ready toggling 1010...
    issued = 0; popped = 0; nd = 0;
    @(negedge clka); start = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clka); start = 1'b0;
      m_ready = (k % 2 == 1);
      if (mem_ena) begin
        check("b_credit", 32'(issued - popped < 4), 1);
        check("b_addr", 32'(mem_addra), issued);
        issued++;
      end
      if (m_valid) begin
        check_pix("b", popped);
        if (m_ready) popped++;
      end
      if (done) begin nd++; break; end
    end
    check("b_npix", popped, 12);
    check("b_ndone", nd, 1);

    // Ready held low for 20 cycles
    issued = 0; popped = 0; nd = 0;
    m_ready = 1'b0;
    @(negedge clka); start = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clka); start = 1'b0;
      m_ready = (k > 20);
      if (mem_ena) begin
        check("c_addr", 32'(mem_addra), issued);
        issued++;
      end
      if (m_valid) begin
        check_pix("c", popped);
        if (m_ready) popped++;
      end
      if (k == 20) begin
        check("c_stall_reads", issued, 4);
        check("c_stall_valid", 32'(m_valid), 1);
      end
      if (done) begin nd++; break; end
    end
    check("c_issued", issued, 12);
    check("c_npix", popped, 12);
    check("c_ndone", nd, 1);

    // Extra start pulses during RUN and DONE
    issued = 0; popped = 0; nd = 0;
    m_ready = 1'b1;
    @(negedge clka); start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clka);
      start = (k == 5) || (k == 15);
      if (mem_ena) begin
        check("d_addr", 32'(mem_addra), issued);
        issued++;
      end
      if (m_valid) begin
        check_pix("d", popped);
        popped++;
      end
      if (done) begin
        check("d_done_t", k, 15);
        nd++;
      end
    end
    start = 1'b0;
    check("d_issued", issued, 12);
    check("d_ndone", nd, 1);
    check("d_idle_busy", 32'(busy), 0);

    // Asynchronous reset at pixel 6, then restart
    hit = 1'b0; n = 0;
    @(negedge clka); start = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clka); start = 1'b0;
      if (m_valid) begin
        if (n == 6) begin hit = 1'b1; break; end
        n++;
      end
    end
    check("e_reach6", 32'(hit), 1);
    rst_n = 1'b0;
    #1;
    check_reset("e_rst");
    @(negedge clka); rst_n = 1'b1;
    n = 0; nd = 0;
    @(negedge clka); start = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clka); start = 1'b0;
      if (m_valid) begin
        if (n == 0) check("e_first_t", k, 3);
        check_pix("e", n);
        n++;
      end
      if (done) begin nd++; break; end
    end
    check("e_npix", n, 12);
    check("e_ndone", nd, 1);

    // RD_LAT = 2 instance
    first = 1'b1; nd = 0;
    @(negedge clka); start2 = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clka); start2 = 1'b0;
      if (m_valid2 && first) begin
        check("f_first_t", k, 4);
        check("f_data", 32'(m_data2), 32'(exp_px(24'h112233)));
        check("f_sof", 32'(m_sof2), 1);
        first = 1'b0;
      end
      if (done2) begin nd++; break; end
    end
    check("f_seen", 32'(first), 0);
    check("f_ndone", nd, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
